ncl4_sync_tx: RTL and testbench

- Clocked-to-NCL transmitter that turns 2-bit binary words into four-rail (1-of-4) NCL DATA/NULL wavefronts.
- It drives the input of an asynchronous four-rail pipeline stage and paces itself off that stage's completion signal.
- It is the source end of the four-rail pipeline protocol: it replaces a free-running ring generator with a controllable clocked producer.
- A small input FIFO decouples the valid/ready producer from pipeline timing.

---
 rtl/ncl4_sync_tx.sv | 125 ++++++++++++
 tb/tb_ncl4_sync_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncl4_sync_tx.sv
// rtl/ncl4_sync_tx.sv - clocked producer of four-rail NCL DATA/NULL wavefronts
// Input FIFO feeds a DATA/NULL/IDLE handshake paced by a synchronized ZCOMP.
module ncl4_sync_tx #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             init,
    input  logic [1:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       Z,
    input  logic             ZCOMP,
    output logic             busy,
    output logic [CNT_W-1:0] sent_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_NULL
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             z_q, z_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW:0]            cnt_q, cnt_d;
    logic [CNT_W-1:0]       sent_q, sent_d;
    logic                   rdy_q;
    logic [1:0]             mem_q [DEPTH];

    logic zcomp_s;
    logic full;
    logic empty;
    logic push;
    logic pop;

    assign zcomp_s    = sync_q[SYNC_STAGES-1];
    assign full       = (cnt_q == DEPTH_C);
    assign empty      = (cnt_q == '0);
    // rdy_q keeps in_ready low until the first edge after init is released
    assign in_ready   = rdy_q && !full;
    assign push       = in_valid && in_ready;
    assign busy       = !empty || (state_q != S_IDLE);
    assign Z          = z_q;
    assign sent_count = sent_q;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], ZCOMP};
        state_d  = state_q;
        z_d      = z_q;
        sent_d   = sent_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && !zcomp_s) begin
                    state_d = S_DATA;
                    z_d     = 4'b0001 << mem_q[rd_ptr_q];
                end
            end
            S_DATA: begin
                // head stays queued until the receiver acknowledges it
                if (zcomp_s) begin
                    pop     = 1'b1;
                    sent_d  = sent_q + CNT_W'(1);
                    z_d     = 4'b0000;
                    state_d = S_NULL;
                end
            end
            S_NULL: begin
                if (!zcomp_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                z_d     = 4'b0000;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + (PW+1)'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q  <= S_IDLE;
            z_q      <= 4'b0000;
            sync_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            sent_q   <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            z_q      <= z_d;
            sync_q   <= sync_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            sent_q   <= sent_d;
            rdy_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_ncl4_sync_tx.sv
// tb/tb_ncl4_sync_tx.sv - scoreboard bench for ncl4_sync_tx with a ZCOMP responder
module tb_ncl4_sync_tx;

    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 16;

    logic             clk;
    logic             init;
    logic [1:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       Z;
    logic             ZCOMP;
    logic             busy;
    logic [CNT_W-1:0] sent_count;

    int n_vec  = 0;
    int n_fail = 0;
    int zmode  = 1;   // 0: auto responder, 1: force low, 2: force high
    logic [3:0] sb [$];

    ncl4_sync_tx #(
        .DEPTH      (DEPTH),
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .init      (init),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Z         (Z),
        .ZCOMP     (ZCOMP),
        .busy      (busy),
        .sent_count(sent_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receiving stage model: ZCOMP follows Z with a three-edge delay
    int nz_cnt = 0;
    int z_cnt  = 0;
    initial begin
        ZCOMP = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (Z !== 4'b0000) begin
                if (nz_cnt < 1000) nz_cnt++;
                z_cnt = 0;
            end else begin
                if (z_cnt < 1000) z_cnt++;
                nz_cnt = 0;
            end
            if (zmode == 1) ZCOMP = 1'b0;
            else if (zmode == 2) ZCOMP = 1'b1;
            else if (nz_cnt >= 4) ZCOMP = 1'b1;
            else if (z_cnt >= 4) ZCOMP = 1'b0;
        end
    end

    // Output monitor: each NULL-to-DATA onset must match the scoreboard head
    logic [3:0] prev_z = 4'b0000;
    logic [3:0] exp_z;
    initial begin
        forever begin
            @(negedge clk);
            if (Z !== 4'b0000) begin
                if (prev_z === 4'b0000) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_data", {28'd0, Z}, 32'd0);
                    end else begin
                        exp_z = sb.pop_front();
                        chk("data_order", {28'd0, Z}, {28'd0, exp_z});
                    end
                end else begin
                    chk("data_stable", {28'd0, Z}, {28'd0, prev_z});
                end
            end
            prev_z = Z;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [1:0] v);
        logic acc;
        acc = 1'b0;
        @(posedge clk);
        #1;
        in_data  = v;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (acc) sb.push_back(4'b0001 << v);
        else chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    logic [1:0] stream_v [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
    logic [1:0] full_v   [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
    int  n;
    logic found;

    initial begin
        init     = 1'b1;
        in_valid = 1'b0;
        in_data  = 2'd0;
        zmode    = 1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_z", {28'd0, Z}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_sent", {16'd0, sent_count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        init = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rel_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        zmode = 0;

        // Single word: latency and NULL return timing
        push(2'd2);
        chk("single_z_before", {28'd0, Z}, 32'd0);
        @(posedge clk);
        #1;
        chk("single_z_latency", {28'd0, Z}, 32'h4);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #3;
            if (ZCOMP) begin
                found = 1'b1;
                break;
            end
        end
        chk("single_zcomp_seen", {31'd0, found}, 32'd1);
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (Z === 4'b0000) break;
        end
        chk("single_null_after_zcomp", n, SYNC_STAGES + 1);
        wait_idle("single_idle_timeout");
        chk("single_sent", {16'd0, sent_count}, 32'd1);
        chk("single_busy", {31'd0, busy}, 32'd0);
        chk("single_sb_empty", sb.size(), 32'd0);

        // Stream of six words
        for (int i = 0; i < 6; i++) push(stream_v[i]);
        wait_idle("stream_idle_timeout");
        chk("stream_sent", {16'd0, sent_count}, 32'd7);
        chk("stream_sb_empty", sb.size(), 32'd0);

        // Full FIFO with the first DATA never acknowledged
        zmode = 1;
        for (int i = 0; i < DEPTH; i++) push(full_v[i]);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_z_head", {28'd0, Z}, 32'h8);
        in_data  = 2'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_extra_ignored", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("full_busy", {31'd0, busy}, 32'd1);
        zmode = 0;
        wait_idle("full_drain_timeout");
        chk("full_sent", {16'd0, sent_count}, 32'd11);
        chk("full_sb_empty", sb.size(), 32'd0);

        // ZCOMP high across reset release
        zmode = 2;
        @(posedge clk);
        #1;
        sb.delete();
        init = 1'b1;
        @(negedge clk);
        chk("zh_rst_sent", {16'd0, sent_count}, 32'd0);
        @(posedge clk);
        #1;
        init = 1'b0;
        push(2'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("zh_hold_null", {28'd0, Z}, 32'd0);
        end
        @(posedge clk);
        #1;
        zmode = 1;
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (Z !== 4'b0000) break;
        end
        chk("zh_data_within", {31'd0, (n <= SYNC_STAGES + 1)}, 32'd1);
        chk("zh_data_value", {28'd0, Z}, 32'h2);
        zmode = 0;
        wait_idle("zh_idle_timeout");
        chk("zh_sent", {16'd0, sent_count}, 32'd1);

        // Reset in the middle of a transfer discards queued words
        push(2'd1);
        push(2'd2);
        push(2'd3);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (Z === 4'b0010) begin
                found = 1'b1;
                break;
            end
        end
        chk("mid_data_seen", {31'd0, found}, 32'd1);
        #1;
        init = 1'b1;
        #1;
        chk("mid_z_async", {28'd0, Z}, 32'd0);
        chk("mid_sent", {16'd0, sent_count}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_in_ready", {31'd0, in_ready}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        init = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_post_z", {28'd0, Z}, 32'd0);
        chk("mid_post_sent", {16'd0, sent_count}, 32'd0);
        chk("mid_post_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
